// File: rtl/demux_8bit_stream.sv
// Byte-stream demultiplexer: routes each accepted byte to one of two channel FIFOs
// (sel=0 -> channel 1, sel=1 -> channel 2) and counts bytes delivered per channel.
module demux_8bit_stream #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_sel,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out1_data,
    output logic       out1_valid,
    input  logic       out1_ready,
    output logic [7:0] out2_data,
    output logic       out2_valid,
    input  logic       out2_ready,
    output logic [7:0] cnt1,
    output logic [7:0] cnt2
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    r_mem1 [DEPTH];
    logic [7:0]    r_mem2 [DEPTH];
    logic [AW-1:0] r_wr1, r_rd1, r_wr2, r_rd2;
    logic [AW:0]   r_occ1, r_occ2;
    logic [7:0]    r_cnt1, r_cnt2;

    logic w_full1, w_full2, w_push1, w_push2, w_pop1, w_pop2;

    // Valid/ready: a transfer happens on a rising edge where both valid and ready are
    // high. in_ready depends only on in_sel and the full flags (never on in_valid or a
    // same-cycle pop); outN_valid depends only on FIFO occupancy.
    assign w_full1    = (r_occ1 == FULL_CNT);
    assign w_full2    = (r_occ2 == FULL_CNT);
    assign in_ready   = in_sel ? ~w_full2 : ~w_full1;
    assign w_push1    = in_valid & in_ready & ~in_sel;
    assign w_push2    = in_valid & in_ready & in_sel;
    assign out1_valid = (r_occ1 != '0);
    assign out2_valid = (r_occ2 != '0);
    assign w_pop1     = out1_valid & out1_ready;
    assign w_pop2     = out2_valid & out2_ready;
    assign out1_data  = r_mem1[r_rd1];
    assign out2_data  = r_mem2[r_rd2];
    assign cnt1       = r_cnt1;
    assign cnt2       = r_cnt2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem1[i] <= 8'h00;
            r_wr1  <= '0;
            r_rd1  <= '0;
            r_occ1 <= '0;
            r_cnt1 <= 8'h00;
        end else begin
            if (w_push1) begin
                r_mem1[r_wr1] <= in_data;
                r_wr1         <= r_wr1 + PTR_ONE;
            end
            if (w_pop1) begin
                r_rd1  <= r_rd1 + PTR_ONE;
                r_cnt1 <= r_cnt1 + 8'd1;
            end
            if (w_push1 && !w_pop1)      r_occ1 <= r_occ1 + OCC_ONE;
            else if (!w_push1 && w_pop1) r_occ1 <= r_occ1 - OCC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem2[i] <= 8'h00;
            r_wr2  <= '0;
            r_rd2  <= '0;
            r_occ2 <= '0;
            r_cnt2 <= 8'h00;
        end else begin
            if (w_push2) begin
                r_mem2[r_wr2] <= in_data;
                r_wr2         <= r_wr2 + PTR_ONE;
            end
            if (w_pop2) begin
                r_rd2  <= r_rd2 + PTR_ONE;
                r_cnt2 <= r_cnt2 + 8'd1;
            end
            if (w_push2 && !w_pop2)      r_occ2 <= r_occ2 + OCC_ONE;
            else if (!w_push2 && w_pop2) r_occ2 <= r_occ2 - OCC_ONE;
        end
    end
endmodule

// File: tb/tb_demux_8bit_stream.sv
// Directed and randomized checks of demux_8bit_stream with DEPTH = 2: routing,
// backpressure, push/pop overlap, counter wrap, async reset and a scoreboard soak.
module tb_demux_8bit_stream;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out1_data, out2_data;
    logic       out1_valid, out2_valid;
    logic       out1_ready = 1'b0;
    logic       out2_ready = 1'b0;
    logic [7:0] cnt1, cnt2;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] exp_q1[$];
    logic [7:0] exp_q2[$];
    logic [7:0] exp_cnt1, exp_cnt2;

    demux_8bit_stream #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
        .cnt1(cnt1), .cnt2(cnt2)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        // reset values
        #2;
        check_val("rst_out1_valid", 32'(out1_valid), 32'd0);
        check_val("rst_out2_valid", 32'(out2_valid), 32'd0);
        check_val("rst_out1_data", 32'(out1_data), 32'h00);
        check_val("rst_out2_data", 32'(out2_data), 32'h00);
        check_val("rst_cnt1", 32'(cnt1), 32'd0);
        check_val("rst_cnt2", 32'(cnt2), 32'd0);
        check_val("rst_in_ready_sel0", 32'(in_ready), 32'd1);
        in_sel = 1'b1;
        #1;
        check_val("rst_in_ready_sel1", 32'(in_ready), 32'd1);
        do_reset();

        // basic routing
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        drive(1'b1, 1'b0, 8'hA5);
        tick();
        check_val("route_out1_valid", 32'(out1_valid), 32'd1);
        check_val("route_out1_data", 32'(out1_data), 32'hA5);
        drive(1'b1, 1'b1, 8'h3C);
        tick();
        check_val("route_out1_drained", 32'(out1_valid), 32'd0);
        check_val("route_out2_valid", 32'(out2_valid), 32'd1);
        check_val("route_out2_data", 32'(out2_data), 32'h3C);
        drive(1'b0, 1'b0, 8'h00);
        tick();
        check_val("route_cnt1", 32'(cnt1), 32'd1);
        check_val("route_cnt2", 32'(cnt2), 32'd1);

        // full / backpressure
        do_reset();
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h01);
        check_val("bp_ready_empty", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 1'b0, 8'h02);
        check_val("bp_ready_one", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 1'b0, 8'h03);
        check_val("bp_ready_full", 32'(in_ready), 32'd0);
        tick();
        check_val("bp_held_head", 32'(out1_data), 32'h01);
        drive(1'b1, 1'b1, 8'h77);
        check_val("bp_ready_other_ch", 32'(in_ready), 32'd1);
        tick();
        check_val("bp_ch2_valid", 32'(out2_valid), 32'd1);
        check_val("bp_ch2_data", 32'(out2_data), 32'h77);
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h03);
        check_val("bp_ready_still_full", 32'(in_ready), 32'd0);
        tick();
        check_val("bp_drain_second", 32'(out1_data), 32'h02);
        check_val("bp_ready_after_pop", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        check_val("bp_third_head", 32'(out1_data), 32'h03);
        check_val("bp_third_valid", 32'(out1_valid), 32'd1);
        tick();
        check_val("bp_empty", 32'(out1_valid), 32'd0);
        check_val("bp_cnt1", 32'(cnt1), 32'd3);
        check_val("bp_cnt2", 32'(cnt2), 32'd1);

        // simultaneous push/pop at occupancy 1
        do_reset();
        out1_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h10);
        tick();
        out1_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 8'(8'h11 + i));
            check_val("pp_head", 32'(out1_data), 32'(8'h10 + i));
            check_val("pp_ready", 32'(in_ready), 32'd1);
            tick();
        end
        drive(1'b0, 1'b0, 8'h00);
        check_val("pp_occ_one", 32'(out1_valid), 32'd1);
        check_val("pp_last_head", 32'(out1_data), 32'h24);
        check_val("pp_cnt1", 32'(cnt1), 32'd20);

        // counter wrap on channel 2
        do_reset();
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 1'b1, 8'(i));
            tick();
        end
        drive(1'b0, 1'b0, 8'h00);
        check_val("wrap_last_data", 32'(out2_data), 32'h00);
        tick();
        check_val("wrap_cnt2", 32'(cnt2), 32'd1);
        check_val("wrap_cnt1", 32'(cnt1), 32'd0);

        // mid-run async reset with both FIFOs partially full
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hE1);
        tick();
        drive(1'b1, 1'b1, 8'hE2);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_out1_valid", 32'(out1_valid), 32'd0);
        check_val("mid_rst_out2_valid", 32'(out2_valid), 32'd0);
        check_val("mid_rst_cnt2", 32'(cnt2), 32'd0);
        check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(1'b1, 1'b0, 8'h55);
        tick();
        drive(1'b1, 1'b1, 8'h66);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        check_val("post_rst_out1", 32'(out1_data), 32'h55);
        check_val("post_rst_out2", 32'(out2_data), 32'h66);

        // random soak against scoreboard
        do_reset();
        exp_q1.delete();
        exp_q2.delete();
        exp_cnt1 = 8'h00;
        exp_cnt2 = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            logic mdl_ready;
            out1_ready = ($urandom_range(0, 3) != 0);
            out2_ready = ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            mdl_ready = in_sel ? (exp_q2.size() < DEPTH) : (exp_q1.size() < DEPTH);
            check_val("soak_in_ready", 32'(in_ready), 32'(mdl_ready));
            check_val("soak_out1_valid", 32'(out1_valid), 32'(exp_q1.size() != 0));
            check_val("soak_out2_valid", 32'(out2_valid), 32'(exp_q2.size() != 0));
            if (exp_q1.size() != 0) begin
                check_val("soak_out1_data", 32'(out1_data), 32'(exp_q1[0]));
                if (out1_ready) begin
                    void'(exp_q1.pop_front());
                    exp_cnt1 = exp_cnt1 + 8'd1;
                end
            end
            if (exp_q2.size() != 0) begin
                check_val("soak_out2_data", 32'(out2_data), 32'(exp_q2[0]));
                if (out2_ready) begin
                    void'(exp_q2.pop_front());
                    exp_cnt2 = exp_cnt2 + 8'd1;
                end
            end
            if (in_valid && mdl_ready) begin
                if (in_sel) exp_q2.push_back(in_data);
                else        exp_q1.push_back(in_data);
            end
            tick();
            if (c % 64 == 63) begin
                check_val("soak_cnt1", 32'(cnt1), 32'(exp_cnt1));
                check_val("soak_cnt2", 32'(cnt2), 32'(exp_cnt2));
            end
        end
        in_valid = 1'b0;
        #1;
        check_val("soak_final_cnt1", 32'(cnt1), 32'(exp_cnt1));
        check_val("soak_final_cnt2", 32'(cnt2), 32'(exp_cnt2));

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/demux_8bit_stream.md
# demux_8bit_stream

Routes an 8-bit valid/ready byte stream to one of two output channels, chosen per byte by a select bit. It performs the inverse of the team's 8-bit 2:1 select path: `sel=0` maps to channel 1 and `sel=1` maps to channel 2. Each channel has its own small FIFO, so a stalled consumer on one channel never blocks bytes headed to the other. Per-channel delivery counters support debug and display logic.

## Interface
- `DEPTH`, default 2: entries per channel FIFO. Must be a power of two and at least 2.
- `clk`, input, 1: single clock, rising-edge active.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_data`, input, 8: byte offered by the upstream producer.
- `in_sel`, input, 1: destination of the offered byte. 0 selects channel 1; 1 selects channel 2.
- `in_valid`, input, 1: upstream has a byte on `in_data`/`in_sel`.
- `in_ready`, output, 1: the block can accept the offered byte this cycle.
- `out1_data`, output, 8: head byte of channel 1.
- `out1_valid`, output, 1: channel 1 FIFO is non-empty.
- `out1_ready`, input, 1: channel 1 consumer takes the head byte.
- `out2_data`, output, 8: head byte of channel 2.
- `out2_valid`, output, 1: channel 2 FIFO is non-empty.
- `out2_ready`, input, 1: channel 2 consumer takes the head byte.
- `cnt1`, output, 8: bytes delivered on channel 1, modulo 256.
- `cnt2`, output, 8: bytes delivered on channel 2, modulo 256.

## Operation
- **Channel FIFOs:** each channel has its own FIFO with `DEPTH` entries of 8-bit storage.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy is tracked with a count register that is log2(DEPTH)+1 bits wide.
- **Input handshake:**
  - `in_ready` = NOT full(FIFO selected by `in_sel`). It is combinational from `in_sel` and the full flags only; it does not depend on `in_valid`.
  - A byte is accepted when `in_valid && in_ready` is high at a rising edge. It is written at the write pointer of the selected FIFO, and that pointer advances.
  - `in_ready` never looks ahead to a same-cycle pop. A full FIFO refuses input even if its consumer is reading in that cycle.
- **Output handshake (per channel):**
  - `outN_valid` = count != 0.
  - `outN_data` = storage at the read pointer. It is driven from registers and holds stable while valid is high and ready is low.
  - A pop occurs when `outN_valid && outN_ready` is high at an edge. The read pointer advances.
  - `outN_ready` has no effect while `outN_valid` is 0.
- **Simultaneous events on one FIFO:**
  - Push and pop in the same cycle leave the count unchanged and update both pointers.
  - On a non-empty, non-full FIFO this case is legal.
  - On an empty FIFO only the push occurs, because valid is 0.
  - On a full FIFO only the pop occurs, because `in_ready` is 0.
- **Channel independence:** a pop on channel 1 and a push to channel 2, or any other combination, proceed in the same cycle.
- **Ordering:** bytes leave each channel in acceptance order. No ordering holds across channels.
- **Counters:** `cntN` increments by 1 on each pop of channel N and wraps from 255 to 0.
- **Illegal input:** none. Any `in_sel` value is legal. An X on `in_sel` while `in_valid` is high is a bench error.

## Timing
- **Reset (async assert, synchronous-edge release):**
  - Both FIFOs empty; all pointers and counts 0.
  - `out1_valid` = `out2_valid` = 0.
  - `out1_data` = `out2_data` = 8'h00, because storage is cleared.
  - `cnt1` = `cnt2` = 0.
  - `in_ready` = 1 for either `in_sel` value.
- **Latency:** a byte accepted at edge k has `outN_valid` high during the cycle after edge k, so first-byte latency is 1 cycle. There is no combinational path from `in_data` to `outN_data`.
- **Throughput:** 1 byte per cycle per input, sustained when the selected consumer holds ready high. This holds with `DEPTH` ≥ 2.
- **Counter update:** `cntN` updates at the same edge as the pop. The new value is visible in the following cycle.
- **Reset mid-operation:** asserting `rst_n` low immediately discards all FIFO contents and clears the counters. Any handshake in progress at that edge is lost, and upstream must resend.

## Test plan
- **Reset values:** drive `rst_n` low mid-run with both FIFOs partially full.
  - Required immediately, without waiting for a clock: both valids 0, both counts 0, `in_ready` = 1.
  - After release, the first byte out on each channel is a byte sent after reset.
- **Basic routing:** with both readies high, send 8'hA5 with sel=0 then 8'h3C with sel=1.
  - `out1_valid`/`out1_data` = 8'hA5 one cycle after the first acceptance.
  - `out2_data` = 8'h3C one cycle after the second acceptance.
  - Final counts: `cnt1` = 1, `cnt2` = 1.
- **Full/backpressure:** with `out1_ready` = 0 and DEPTH = 2, send 8'h01, 8'h02, 8'h03 to channel 1.
  - `in_ready` drops after 2 acceptances, and 8'h03 is held by upstream.
  - Switching `in_sel` to 1 raises `in_ready`. A byte sent there is delivered on channel 2.
  - Raising `out1_ready` drains 8'h01 then 8'h02, after which 8'h03 is accepted.
- **Simultaneous push/pop:** hold channel 1 at count 1 while pushing and popping every cycle for 20 cycles.
  - Count stays 1; `cnt1` = 20.
  - Output sequence equals the input sequence delayed by one byte.
- **Counter wrap:** deliver 257 bytes on channel 2.
  - `cnt2` = 1; `cnt1` = 0.
- **Random soak:** run random `in_valid`, `in_sel`, `out1_ready` and `out2_ready` for 10k cycles against a scoreboard.
  - No loss, duplication or reordering within a channel.
  - Counts match the scoreboard modulo 256.
